// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfx_pkg
//  Description : Shared types and constants for the sound-effect engine:
//                FSM state encoding, default channel assignment and the
//                default tone settings used by the Pong top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package sfx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Default channel assignment; lower index wins arbitration
    localparam int BOUNCE = 0;
    localparam int SCORE  = 1;
    localparam int MENU   = 2;
    localparam int PAUSE  = 3;

    // Default half-periods in 12 MHz clock cycles
    localparam logic [15:0] HP_BOUNCE = 16'd6000;   // 1 kHz
    localparam logic [15:0] HP_SCORE  = 16'd3000;   // 2 kHz
    localparam logic [15:0] HP_MENU   = 16'd4500;
    localparam logic [15:0] HP_PAUSE  = 16'd12000;  // 500 Hz

    // Default durations in 1 ms ticks
    localparam logic [9:0]  DUR_BOUNCE = 10'd40;
    localparam logic [9:0]  DUR_SCORE  = 10'd300;
    localparam logic [9:0]  DUR_MENU   = 10'd60;
    localparam logic [9:0]  DUR_PAUSE  = 10'd150;

endpackage
`default_nettype wire

// File: rtl/sfx_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : sfx_prio_enc
//  Description : Combinational priority encoder, lowest set index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfx_prio_enc #(
    parameter int NUM_EVENTS = 4,
    parameter int ID_W       = $clog2(NUM_EVENTS)
) (
    input  logic [NUM_EVENTS-1:0] req,
    output logic                  valid,
    output logic [ID_W-1:0]       idx
);

    // Scan from the top down so the lowest set index is the last write
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = i[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sfx_engine
//  Description : Multi-channel buzzer tone engine. Rising edges on the event
//                triggers are arbitrated by fixed priority (index 0 highest)
//                and the winner's square-wave tone is played for its
//                duration. Supports preemption, retrigger and mute.
//                Optional macro SFX_QUEUE_EN adds a one-deep pending slot
//                for lower-priority triggers that arrive during a tone.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfx_engine
    import sfx_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int PRESCALE   = 12000,
    parameter int HP_W       = 16,
    parameter int DUR_W      = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_EVENTS-1:0]         event_trig,
    input  logic [NUM_EVENTS*HP_W-1:0]    half_period,
    input  logic [NUM_EVENTS*DUR_W-1:0]   duration,
    input  logic                          mute,
    output logic                          buzzer,
    output logic                          busy,
    output logic [$clog2(NUM_EVENTS)-1:0] active_id
);

    localparam int ID_W  = $clog2(NUM_EVENTS);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

    state_t                r_state, w_state_n;
    logic [NUM_EVENTS-1:0] r_trig_prev, w_dur_nz, w_edge;
    logic                  w_win_valid;
    logic [ID_W-1:0]       w_win_idx;
    logic [HP_W-1:0]       w_win_hp, r_hp, w_hp_n, r_tone_cnt, w_tone_cnt_n;
    logic [DUR_W-1:0]      w_win_dur, r_dur, w_dur_n, r_dur_cnt, w_dur_cnt_n;
    logic [PRE_W-1:0]      r_pre_cnt, w_pre_n;
    logic [ID_W-1:0]       r_active_id, w_id_n;
    logic                  r_tone, w_tone_n, r_buzzer, w_wrap_end;
    logic                  w_load;
    logic [ID_W-1:0]       w_load_idx;
    logic [HP_W-1:0]       w_load_hp;
    logic [DUR_W-1:0]      w_load_dur;

    // A channel with zero duration can never start a tone
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_mask
        assign w_dur_nz[gi] = |duration[gi*DUR_W +: DUR_W];
    end

    assign w_edge = event_trig & ~r_trig_prev & w_dur_nz;

    sfx_prio_enc #(
        .NUM_EVENTS (NUM_EVENTS),
        .ID_W       (ID_W)
    ) u_prio (
        .req   (w_edge),
        .valid (w_win_valid),
        .idx   (w_win_idx)
    );

    assign w_win_hp  = half_period[int'(w_win_idx)*HP_W +: HP_W];
    assign w_win_dur = duration[int'(w_win_idx)*DUR_W +: DUR_W];

`ifdef SFX_QUEUE_EN
    logic            r_pend_valid, w_pend_valid_n, w_pq_valid;
    logic [ID_W-1:0] r_pend_idx, w_pend_idx_n, w_pq_idx;
    logic [HP_W-1:0] w_pq_hp;
    logic [DUR_W-1:0] w_pq_dur;

    // Slot contents including any trigger dropped in this very cycle
    always_comb begin
        w_pq_valid = r_pend_valid;
        w_pq_idx   = r_pend_idx;
        if ((r_state == PLAY) && w_win_valid && (w_win_idx > r_active_id) &&
            (!r_pend_valid || (w_win_idx < r_pend_idx))) begin
            w_pq_valid = 1'b1;
            w_pq_idx   = w_win_idx;
        end
    end

    assign w_pq_hp  = half_period[int'(w_pq_idx)*HP_W +: HP_W];
    assign w_pq_dur = duration[int'(w_pq_idx)*DUR_W +: DUR_W];

    // Pending slot register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_n;
            r_pend_idx   <= w_pend_idx_n;
        end
    end
`endif

    // Next-state logic: tone/duration counters, arbitration and tone loads
    always_comb begin
        w_state_n    = r_state;
        w_hp_n       = r_hp;
        w_dur_n      = r_dur;
        w_id_n       = r_active_id;
        w_tone_n     = r_tone;
        w_tone_cnt_n = r_tone_cnt;
        w_pre_n      = r_pre_cnt;
        w_dur_cnt_n  = r_dur_cnt;
        w_wrap_end   = 1'b0;
        w_load       = 1'b0;
        w_load_idx   = w_win_idx;
        w_load_hp    = w_win_hp;
        w_load_dur   = w_win_dur;
`ifdef SFX_QUEUE_EN
        w_pend_valid_n = r_pend_valid;
        w_pend_idx_n   = r_pend_idx;
`endif
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_load = 1'b1;
                end
            end
            PLAY: begin
                // Zero half-period means a constant-high tone bit
                if (r_hp != '0) begin
                    if (r_tone_cnt == '0) begin
                        w_tone_n     = ~r_tone;
                        w_tone_cnt_n = r_hp - 1'b1;
                    end else begin
                        w_tone_cnt_n = r_tone_cnt - 1'b1;
                    end
                end
                if (r_pre_cnt == c_pre_last) begin
                    w_pre_n     = '0;
                    w_dur_cnt_n = r_dur_cnt - 1'b1;
                    w_wrap_end  = (r_dur_cnt == DUR_W'(1));
                end else begin
                    w_pre_n = r_pre_cnt + 1'b1;
                end

                if (w_win_valid && (w_win_idx < r_active_id)) begin
                    w_load = 1'b1;
                end else if (w_win_valid && (w_win_idx == r_active_id)) begin
                    // Retrigger restarts timing but keeps the tone phase
                    w_pre_n     = '0;
                    w_dur_cnt_n = r_dur;
                end else begin
`ifdef SFX_QUEUE_EN
                    w_pend_valid_n = w_pq_valid;
                    w_pend_idx_n   = w_pq_idx;
                    if (w_wrap_end) begin
                        w_pend_valid_n = 1'b0;
                        w_pend_idx_n   = '0;
                        if (w_pq_valid && (w_pq_dur != '0)) begin
                            w_load     = 1'b1;
                            w_load_idx = w_pq_idx;
                            w_load_hp  = w_pq_hp;
                            w_load_dur = w_pq_dur;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end
`else
                    if (w_wrap_end) begin
                        w_state_n = IDLE;
                    end
`endif
                end
            end
            default: w_state_n = IDLE;
        endcase

        if (w_load) begin
            w_state_n    = PLAY;
            w_hp_n       = w_load_hp;
            w_dur_n      = w_load_dur;
            w_id_n       = w_load_idx;
            w_tone_n     = 1'b1;
            w_tone_cnt_n = w_load_hp - 1'b1;
            w_pre_n      = '0;
            w_dur_cnt_n  = w_load_dur;
        end
    end

    // State and datapath registers; buzzer is registered for a clean output
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_trig_prev <= '0;
            r_hp        <= '0;
            r_dur       <= '0;
            r_active_id <= '0;
            r_tone      <= 1'b0;
            r_tone_cnt  <= '0;
            r_pre_cnt   <= '0;
            r_dur_cnt   <= '0;
            r_buzzer    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_trig_prev <= event_trig;
            r_hp        <= w_hp_n;
            r_dur       <= w_dur_n;
            r_active_id <= w_id_n;
            r_tone      <= w_tone_n;
            r_tone_cnt  <= w_tone_cnt_n;
            r_pre_cnt   <= w_pre_n;
            r_dur_cnt   <= w_dur_cnt_n;
            r_buzzer    <= w_tone_n & (w_state_n == PLAY) & ~mute;
        end
    end

    assign buzzer    = r_buzzer;
    assign busy      = (r_state == PLAY);
    assign active_id = r_active_id;

endmodule
`default_nettype wire

// File: tb/tb_sfx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfx_engine
//  Description : Self-checking bench for sfx_engine (PRESCALE=10, 4 channels).
//                A time-based tone model predicts busy/buzzer/active_id each
//                cycle; directed scenarios add hand-computed totals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sfx_engine;

    localparam int NE  = 4;
    localparam int PS  = 10;
    localparam int HPW = 16;
    localparam int DW  = 10;
`ifdef SFX_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NE-1:0]     event_trig = '0;
    logic [NE*HPW-1:0] half_period = '0;
    logic [NE*DW-1:0]  duration = '0;
    logic              mute = 1'b0;
    logic              buzzer, busy;
    logic [1:0]        active_id;

    sfx_engine #(
        .NUM_EVENTS (NE),
        .PRESCALE   (PS),
        .HP_W       (HPW),
        .DUR_W      (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .event_trig  (event_trig),
        .half_period (half_period),
        .duration    (duration),
        .mute        (mute),
        .buzzer      (buzzer),
        .busy        (busy),
        .active_id   (active_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_busy = 0;
    int n_high = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       t = 0;
    bit       m_busy = 1'b0;
    int       m_id = 0, m_hp = 0, m_dur = 0, m_end = 0, m_phase = 0;
    bit [NE-1:0] m_prev = '0;
    bit       m_pv = 1'b0;
    int       m_pidx = 0;

    function automatic int hp_of(input int c);
        return int'(half_period[c*HPW +: HPW]);
    endfunction

    function automatic int dur_of(input int c);
        return int'(duration[c*DW +: DW]);
    endfunction

    task automatic m_start(input int c);
        m_busy  = 1'b1;
        m_id    = c;
        m_hp    = hp_of(c);
        m_dur   = dur_of(c);
        m_phase = t;
        m_end   = t + m_dur * PS;
    endtask

    task automatic model_step();
        bit [NE-1:0] e;
        int w;
        if (!reset) begin
            m_busy = 1'b0; m_id = 0; m_prev = '0; m_pv = 1'b0; m_pidx = 0;
            return;
        end
        for (int i = 0; i < NE; i++)
            e[i] = event_trig[i] && !m_prev[i] && (dur_of(i) != 0);
        m_prev = event_trig;
        w = -1;
        for (int i = NE - 1; i >= 0; i--)
            if (e[i]) w = i;
        if (!m_busy) begin
            if (w >= 0) m_start(w);
        end else if (w >= 0 && w < m_id) begin
            m_start(w);
        end else if (w >= 0 && w == m_id) begin
            m_end = t + m_dur * PS;
        end else begin
            if (QEN && w >= 0 && (!m_pv || w < m_pidx)) begin
                m_pv = 1'b1; m_pidx = w;
            end
            if (t == m_end) begin
                if (QEN && m_pv && dur_of(m_pidx) != 0) m_start(m_pidx);
                else m_busy = 1'b0;
                m_pv = 1'b0;
            end
        end
    endtask

    // Model update at each edge, compare just after it
    initial begin
        bit tone_bit;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            tone_bit = (m_hp == 0) || ((((t - m_phase) / (m_hp == 0 ? 1 : m_hp)) % 2) == 0);
            chk("busy", busy, m_busy);
            chk("buzzer", buzzer, m_busy && !mute && tone_bit);
            if (m_busy) chk("active_id", active_id, m_id);
            t++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        if (busy === 1'b1) n_busy++;
        if (buzzer === 1'b1) n_high++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int c);
        event_trig[c] = 1'b1;
        tick();
        event_trig[c] = 1'b0;
    endtask

    task automatic set_ch(input int c, input int hp, input int d);
        half_period[c*HPW +: HPW] = HPW'(hp);
        duration[c*DW +: DW]      = DW'(d);
    endtask

    task automatic clr();
        n_busy = 0;
        n_high = 0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        run(3);
        chk("rst_busy", busy, 0);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_id", active_id, 0);
        reset = 1'b1;
        run(2);

        // Single tone on channel 1
        set_ch(1, 3, 5);
        clr(); pulse(1); run(4);
        chk("t1_id", active_id, 1);
        run(65);
        chk("t1_busy_cycles", n_busy, 50);
        chk("t1_high_cycles", n_high, 26);

        // Preemption of channel 2 by channel 0 at cycle 30
        set_ch(2, 4, 20);
        set_ch(0, 2, 3);
        clr(); pulse(2); run(29); pulse(0);
        chk("t2_id", active_id, 0);
        run(60);
        chk("t2_busy_cycles", n_busy, 60);
        chk("t2_high_cycles", n_high, 32);

        // Lower-priority triggers during a tone
        set_ch(0, 2, 2);
        set_ch(3, 5, 4);
        set_ch(2, 3, 3);
        clr(); pulse(0); pulse(3); pulse(2); run(22);
        chk("t3_after_first", QEN ? 32'(active_id) : 32'(busy), QEN ? 2 : 0);
        run(40);
        chk("t3_busy_cycles", n_busy, QEN ? 50 : 20);
        chk("t3_high_cycles", n_high, QEN ? 25 : 10);

        // Held trigger fires once; zero duration never starts
        set_ch(0, 2, 2);
        clr(); event_trig[0] = 1'b1; run(100); event_trig[0] = 1'b0;
        chk("t4_held_busy", n_busy, 20);
        run(5);
        set_ch(1, 3, 0);
        clr(); pulse(1); run(20);
        chk("t4_dur0_busy", n_busy, 0);

        // Mute and constant-high tone
        set_ch(1, 3, 5);
        mute = 1'b1;
        clr(); pulse(1); run(69);
        chk("t5_mute_busy", n_busy, 50);
        chk("t5_mute_high", n_high, 0);
        mute = 1'b0;
        set_ch(3, 0, 4);
        clr(); pulse(3); run(50);
        chk("t5_hp0_busy", n_busy, 40);
        chk("t5_hp0_high", n_high, 40);
        set_ch(1, 3, 5);
        clr(); pulse(1); run(10); mute = 1'b1; run(10); mute = 1'b0; run(50);
        chk("t5_midmute_busy", n_busy, 50);

        // Reset mid-tone, then normal operation
        clr(); pulse(1); run(10);
        reset = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_buzzer", buzzer, 0);
        chk("t6_id", active_id, 0);
        run(2);
        reset = 1'b1;
        clr(); pulse(1); run(60);
        chk("t6_busy_cycles", n_busy, 50);
        chk("t6_high_cycles", n_high, 26);

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
